// File: rtl/data_mem_system.sv
// data_mem_system: byte-maskable data RAM plus MMIO cycle counter, one-shot timer and TX byte FIFO.
module data_mem_system #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
    parameter int          TXQ_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_d_we,
    input  logic [3:0]  mem_d_wmask,
    input  logic [31:0] mem_d_a,
    input  logic [31:0] mem_d_wd,
    output logic [31:0] mem_d_rd,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        timer_irq
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int QW = $clog2(TXQ_DEPTH);
    logic [31:0]   ram [DEPTH_WORDS];
    logic [7:0]    txq [TXQ_DEPTH];
    logic [63:0]   cycle;
    logic [31:0]   timer;
    logic          irq_pending, overflow;
    logic [QW-1:0] rd_ptr, wr_ptr;
    logic [QW:0]   count;
    logic [AW-1:0] widx;
    logic [7:0]    off;
    logic          is_mmio, full, empty, pop, push_req, push, timer_wr, status_w1c, expire;
    assign is_mmio    = mem_d_a >= MMIO_BASE;
    assign widx       = mem_d_a[AW+1:2];
    assign off        = mem_d_a[7:0];
    assign full       = count == (QW+1)'(TXQ_DEPTH);
    assign empty      = count == '0;
    assign pop        = !empty && tx_ready;
    assign push_req   = mem_d_we && is_mmio && off == 8'h10 && mem_d_wmask[0];
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push       = push_req && (!full || pop);
    assign timer_wr   = mem_d_we && is_mmio && off == 8'h08 && mem_d_wmask == 4'hF;
    assign status_w1c = mem_d_we && is_mmio && off == 8'h0C && mem_d_wmask[0];
    assign expire     = !timer_wr && timer == 32'd1;
    assign tx_valid   = !empty;
    assign tx_data    = empty ? 8'h00 : txq[rd_ptr];
    assign timer_irq  = irq_pending;
    assign mem_d_rd   = !is_mmio      ? ram[widx]    :
                        off == 8'h00  ? cycle[31:0]  :
                        off == 8'h04  ? cycle[63:32] :
                        off == 8'h08  ? timer        :
                        off == 8'h0C  ? {23'd0, 5'(count), overflow, empty, full, irq_pending} : 32'd0;
    always_ff @(posedge clk) begin
        if (!reset && mem_d_we && !is_mmio)
            for (int i = 0; i < 4; i++)
                if (mem_d_wmask[i]) ram[widx][8*i +: 8] <= mem_d_wd[8*i +: 8];
        if (!reset && push)
            txq[wr_ptr] <= mem_d_wd[7:0];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle       <= '0;
            timer       <= '0;
            irq_pending <= 1'b0;
            overflow    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            cycle       <= cycle + 64'd1;
            timer       <= timer_wr ? mem_d_wd : timer - 32'(timer != 32'd0);
            // sticky flags: a set event in the same cycle beats the W1C
            irq_pending <= expire || (irq_pending && !(status_w1c && mem_d_wd[0]));
            overflow    <= (push_req && full && !pop) || (overflow && !(status_w1c && mem_d_wd[3]));
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            count       <= count + (QW+1)'(push) - (QW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_data_mem_system.sv
// tb_data_mem_system: directed stimulus against a queue/array reference model of data_mem_system.
module tb_data_mem_system;
    localparam int DW = 1024;
    localparam int QD = 8;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] LO = BASE, HI = BASE + 4, TMR = BASE + 8, STAT = BASE + 12, TXD = BASE + 16;
    logic        clk = 0, reset = 1, mem_d_we = 0, tx_ready = 0;
    logic [3:0]  mem_d_wmask = 0;
    logic [31:0] mem_d_a = 0, mem_d_wd = 0;
    logic [31:0] mem_d_rd;
    logic        tx_valid, timer_irq;
    logic [7:0]  tx_data;
    int checks = 0, passed = 0;
    bit          mok = 0, mirq, movf;
    logic [63:0] mcyc, bias = 0;
    logic [31:0] mt;
    logic [7:0]  mq [$];
    logic [31:0] mm [DW];
    bit          mv [DW];
    logic [32:0] ce;
    always #5 clk = ~clk;
    data_mem_system dut (
        .clk(clk), .reset(reset), .mem_d_we(mem_d_we), .mem_d_wmask(mem_d_wmask),
        .mem_d_a(mem_d_a), .mem_d_wd(mem_d_wd), .mem_d_rd(mem_d_rd),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .timer_irq(timer_irq)
    );
    wire        mmio  = mem_d_a >= BASE;
    wire [7:0]  moff  = mem_d_a[7:0];
    wire [31:0] midx  = (mem_d_a >> 2) % DW;
    wire        twr   = mem_d_we && mmio && moff == 8'h08 && mem_d_wmask == 4'hF;
    wire        w1c   = mem_d_we && mmio && moff == 8'h0C && mem_d_wmask[0];
    wire        pushr = mem_d_we && mmio && moff == 8'h10 && mem_d_wmask[0];
    always @(posedge clk) begin
        if (reset) begin
            mok <= 1; mcyc <= 0; mt <= 0; mirq <= 0; movf <= 0;
            mq.delete();
        end else begin
            mcyc <= mcyc + 1;
            if (mem_d_we && !mmio) begin
                for (int i = 0; i < 4; i++)
                    if (mem_d_wmask[i]) mm[midx][8*i +: 8] <= mem_d_wd[8*i +: 8];
                if (mem_d_wmask == 4'hF) mv[midx] <= 1;
            end
            if (twr) mt <= mem_d_wd;
            else if (mt != 0) mt <= mt - 1;
            if (!twr && mt == 1) mirq <= 1;
            else if (w1c && mem_d_wd[0]) mirq <= 0;
            if (pushr && mq.size() == QD && !tx_ready) movf <= 1;
            else if (w1c && mem_d_wd[3]) movf <= 0;
            if (mq.size() != 0 && tx_ready) begin
                if (pushr) mq.push_back(mem_d_wd[7:0]);
                void'(mq.pop_front());
            end else if (pushr && mq.size() < QD) mq.push_back(mem_d_wd[7:0]);
        end
    end
    function automatic logic [32:0] exp_rd(input logic [31:0] a);
        logic [63:0] c = mcyc + bias;
        int n = mq.size();
        int k = int'((a >> 2) % DW);
        if (a < BASE) return {mv[k], mm[k]};
        case (a[7:0])
            8'h00:   return {1'b1, c[31:0]};
            8'h04:   return {1'b1, c[63:32]};
            8'h08:   return {1'b1, mt};
            8'h0C:   return {1'b1, 23'd0, 5'(n), movf, n == 0, n == QD, mirq};
            default: return {1'b1, 32'd0};
        endcase
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask
    always @(negedge clk) begin
        #2;
        if (mok) begin
            chk("tx_valid", tx_valid, mq.size() != 0);
            chk("tx_data", tx_data, mq.size() != 0 ? mq[0] : 8'h00);
            chk("timer_irq", timer_irq, mirq);
            ce = exp_rd(mem_d_a);
            if (ce[32]) chk("mem_d_rd", mem_d_rd, ce[31:0]);
        end
    end
    task automatic cyc(input logic we, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d, input logic r);
        @(negedge clk);
        reset = 0; mem_d_we = we; mem_d_wmask = m; mem_d_a = a; mem_d_wd = d; tx_ready = r;
    endtask
    task automatic rd(input logic [31:0] a, input logic r, input string nm, input logic [31:0] e);
        cyc(0, 0, a, 0, r);
        #3 chk(nm, mem_d_rd, e);
    endtask
    initial begin
        @(negedge clk); @(negedge clk);
        mem_d_a = LO;
        #3;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_irq", timer_irq, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_cycle", mem_d_rd, 0);
        repeat (11) cyc(0, 0, LO, 0, 0);
        #3 chk("cycle_lo_10", mem_d_rd, 10);
        cyc(1, 4'hF, 32'h40, 32'hDEAD_BEEF, 0);
        cyc(1, 4'h1, 32'h40, 32'h0000_00AA, 0);
        rd(32'h40, 0, "ram_mask", 32'hDEAD_BEAA);
        cyc(1, 4'hF, 32'h40 + 4 * DW, 32'h1234_5678, 0);
        rd(32'h43, 0, "ram_alias", 32'h1234_5678);
        cyc(1, 4'h6, 32'h40, 32'hA5A5_A5A5, 0);
        rd(32'h40, 0, "ram_mid_lanes", 32'h12A5_A578);
        cyc(1, 4'hF, TMR, 3, 0);
        rd(TMR, 0, "timer_3", 3);
        rd(TMR, 0, "timer_2", 2);
        rd(TMR, 0, "timer_1", 1);
        chk("irq_before_expiry", timer_irq, 0);
        rd(TMR, 0, "timer_0", 0);
        chk("irq_on_expiry", timer_irq, 1);
        cyc(1, 4'h1, STAT, 1, 0);
        rd(STAT, 0, "status_after_w1c", 32'h4);
        chk("irq_cleared", timer_irq, 0);
        cyc(1, 4'h3, TMR, 5, 0);
        rd(TMR, 0, "timer_partial_mask", 0);
        cyc(1, 4'hF, TMR, 2, 0);
        cyc(1, 4'hF, TMR, 0, 0);
        repeat (3) rd(TMR, 0, "timer_stopped", 0);
        chk("irq_load0", timer_irq, 0);
        cyc(1, 4'hF, TMR, 1, 0);
        cyc(1, 4'h1, STAT, 1, 0);
        rd(STAT, 0, "expiry_beats_w1c", 32'h5);
        cyc(1, 4'h1, STAT, 1, 0);
        rd(STAT, 0, "irq_w1c_again", 32'h4);
        for (int i = 0; i < 9; i++) cyc(1, 4'h1, TXD, 32'h41 + i, 0);
        rd(STAT, 0, "fifo_full_ovf", 32'h8A);
        for (int i = 0; i < 8; i++) begin
            rd(TXD, 1, "txdata_reads_0", 0);
            chk("drain_order", tx_data, 8'h41 + i);
        end
        rd(STAT, 0, "fifo_empty_ovf", 32'h0C);
        cyc(1, 4'h1, STAT, 8, 0);
        rd(STAT, 0, "ovf_cleared", 32'h4);
        for (int i = 0; i < 8; i++) cyc(1, 4'h1, TXD, 32'h50 + i, 0);
        cyc(1, 4'h1, TXD, 32'h58, 1);
        rd(STAT, 0, "full_push_pop", 32'h82);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, STAT, 0, 1);
            #3 chk("drain_after_pushpop", tx_data, 8'h51 + i);
        end
        rd(STAT, 0, "empty_again", 32'h4);
        for (int i = 0; i < 5; i++) cyc(1, 4'h1, TXD, 32'h60 + i, 0);
        rd(STAT, 0, "five_entries", 32'h50);
        cyc(1, 4'hF, TMR, 7, 0);
        @(negedge clk);
        reset = 1; mem_d_we = 0; mem_d_a = TMR;
        #3 chk("timer_7_at_reset", mem_d_rd, 7);
        @(negedge clk);
        mem_d_a = LO;
        #3;
        chk("reset_tx_valid", tx_valid, 0);
        chk("reset_irq", timer_irq, 0);
        chk("reset_cycle_lo", mem_d_rd, 0);
        mem_d_a = TMR;
        #1 chk("reset_timer", mem_d_rd, 0);
        repeat (3) cyc(0, 0, LO, 0, 0);
        bias = 64'hFFFF_FFFF - mcyc;
        force dut.cycle = 64'hFFFF_FFFF;
        #1 release dut.cycle;
        #2 chk("cycle_pre_wrap", mem_d_rd, 32'hFFFF_FFFF);
        rd(LO, 0, "cycle_lo_wrap", 0);
        rd(HI, 0, "cycle_hi_carry", 1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
